// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar slave-port arbiter.
//   NUM_MASTERS_DEF : default number of requesting masters
//   idx_w()         : width of a master index (at least 1 bit)
//   arb_state_e     : arbiter FSM states
package xbar_pkg;

  localparam int NUM_MASTERS_DEF = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// The search starts one past `last` (wrapping) so the previous winner has the
// lowest priority. The request vector is duplicated to double width and
// shifted right by the start index; the lowest set bit of the low half is the
// winner relative to `start`, which is then mapped back to an absolute index.
// Ports:
//   req     in  N     request vector
//   last    in  IW    index of the previous winner
//   win     out N     one-hot winner (zero when no request)
//   win_idx out IW    index of the winner (zero when no request)
//   any     out 1     at least one request present
module rr_picker
  import xbar_pkg::*;
#(
  parameter  int N  = NUM_MASTERS_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  logic [IW-1:0]  start;
  logic [IW:0]    sum;

  always_comb begin
    start = (last == IW'(N - 1)) ? '0 : last + 1'b1;
    dbl   = {req, req};
    rot   = dbl >> start;
    sum   = '0;
    any   = |req;
    // Walk downward so the lowest set bit (highest priority) is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, start} + (IW + 1)'(i);
      end
    end
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    win_idx = sum[IW-1:0];
    win     = any ? ({{(N - 1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port arbiter: shares one slave port between NUM_MASTERS masters.
// Round-robin grant, held for a whole transaction until the slave acks, the
// holder withdraws its request, or a timeout expires.
//
// Handshake: req_i[m] is a level held by master m for the whole transaction;
// the slave ends it with a single-cycle ack_i pulse. A grant is only ever
// released on ack_i, on the holder dropping req_i, or on timeout; on release
// the next winner is chosen in the same cycle, so there is no idle bubble.
//
// Ports:
//   clk          in   1            rising-edge clock
//   rst_n        in   1            asynchronous active-low reset
//   req_i        in   NUM_MASTERS  per-master request level
//   ack_i        in   1            slave ack pulse ending the transaction
//   grant_o      out  NUM_MASTERS  registered one-hot grant
//   grant_idx_o  out  IDX_W        index of the granted master (valid when busy_o)
//   busy_o       out  1            a grant is active
//   timeout_o    out  1            one-cycle pulse: grant released by timeout
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter  int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter  int TIMEOUT_CYC = 255,
  parameter  int CNT_W       = 8,
  localparam int IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   ack_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tout_q, tout_d;

  logic [NUM_MASTERS-1:0] pick_win;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   holder_req;
  logic                   at_limit;
  logic                   release_c;

  // last_q always equals the current holder while in GRANT, so one picker
  // serves both the idle pick and the re-arbitration on release.
  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req     (req_i),
    .last    (last_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign holder_req = req_i[idx_q];
  assign at_limit   = TO_EN && (cnt_q == TO_LAST);
  assign release_c  = ack_i || !holder_req || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_win;
          idx_d   = pick_idx;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (release_c) begin
          // Timeout is only reported when it is the sole reason for release.
          tout_d = at_limit && !ack_i && holder_req;
          cnt_d  = '0;
          if (pick_any) begin
            grant_d = pick_win;
            idx_d   = pick_idx;
            last_d  = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = |grant_q;
  assign timeout_o   = tout_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_busy:   assert property (@(posedge clk) disable iff (!rst_n) busy_o == (state_q == GRANT));
  a_idx:    assert property (@(posedge clk) disable iff (!rst_n) busy_o |-> grant_q[idx_q]);
  a_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                             (state_q == GRANT && !release_c) |=> $stable(grant_q));

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
module tb_xbar_slave_arbiter;

  localparam int TO = 4;
  localparam int NM [2] = '{2, 4};

  logic       clk;
  logic       rst_n;
  logic [3:0] req_v [2];
  logic       ack_v [2];

  logic [1:0] grant_a;
  logic [0:0] idx_a;
  logic       busy_a, tout_a;
  logic [3:0] grant_b;
  logic [1:0] idx_b;
  logic       busy_b, tout_b;

  int errors = 0;
  int checks = 0;

  // reference model state: owner = -1 means no grant
  int m_owner [2];
  int m_last  [2];
  int m_cnt   [2];
  bit m_tout  [2];

  xbar_slave_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYC(TO), .CNT_W(8)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_v[0][1:0]),
    .ack_i       (ack_v[0]),
    .grant_o     (grant_a),
    .grant_idx_o (idx_a),
    .busy_o      (busy_a),
    .timeout_o   (tout_a)
  );

  xbar_slave_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYC(TO), .CNT_W(8)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_v[1]),
    .ack_i       (ack_v[1]),
    .grant_o     (grant_b),
    .grant_idx_o (idx_b),
    .busy_o      (busy_b),
    .timeout_o   (tout_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int pick(input logic [3:0] r, input int last, input int n);
    int c;
    for (int i = 1; i <= n; i++) begin
      c = (last + i) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = NM[k] - 1;
      m_cnt[k]   = 0;
      m_tout[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int w;
    bit lim;
    bit hreq;
    m_tout[k] = 1'b0;
    if (m_owner[k] < 0) begin
      w = pick(req_v[k], m_last[k], NM[k]);
      if (w >= 0) begin
        m_owner[k] = w;
        m_last[k]  = w;
        m_cnt[k]   = 0;
      end
    end else begin
      lim  = (m_cnt[k] == TO - 1);
      hreq = req_v[k][m_owner[k]];
      if (ack_v[k] || !hreq || lim) begin
        m_tout[k] = !ack_v[k] && hreq && lim;
        w = pick(req_v[k], m_owner[k], NM[k]);
        m_cnt[k] = 0;
        if (w >= 0) begin
          m_owner[k] = w;
          m_last[k]  = w;
        end else begin
          m_owner[k] = -1;
        end
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  // packed view: {busy, timeout, idx (0 when idle), grant}
  function automatic logic [7:0] obs(input int k);
    logic [3:0] g;
    logic [1:0] i;
    logic       b, t;
    if (k == 0) begin
      g = {2'b00, grant_a}; i = {1'b0, idx_a}; b = busy_a; t = tout_a;
    end else begin
      g = grant_b; i = idx_b; b = busy_b; t = tout_b;
    end
    return {b, t, (b ? i : 2'b00), g};
  endfunction

  function automatic logic [7:0] expv(input int k);
    logic [3:0] g;
    logic [1:0] i;
    logic       b;
    b = (m_owner[k] >= 0);
    g = b ? (4'b0001 << m_owner[k]) : 4'b0000;
    i = b ? 2'(m_owner[k]) : 2'b00;
    return {b, m_tout[k], i, g};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] r, input logic a);
    for (int k = 0; k < 2; k++) begin
      req_v[k] = (k == 0) ? (r & 4'b0011) : r;
      ack_v[k] = a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(4'b0000, 1'b0);
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b0011, 1'b0);
    #3;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 8'h00) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %b want %b", k, obs(k), 8'h00);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== expv(k) || obs(k) !== 8'b1000_0001) begin
        errors++;
        $display("FAIL reset_first_grant inst%0d: got %b want %b", k, obs(k), 8'b1000_0001);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(4'b0011, (i % 3) == 2);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k) || obs(k)[7] !== 1'b1) begin
          errors++;
          $display("FAIL round_robin inst%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
        end
      end
    end
    drive(4'b0011, 1'b0);
  endtask

  task automatic test_hold();
    apply_reset();
    drive(4'b0001, 1'b0);
    tick();
    tick();
    drive(4'b0011, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k)[3:0] !== 4'b0001 || obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL hold inst%0d: got %b want grant 0001", k, obs(k));
        end
      end
    end
    drive(4'b0011, 1'b1);
    tick();
    drive(4'b0011, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k)[3:0] !== 4'b0010 || obs(k) !== expv(k)) begin
        errors++;
        $display("FAIL hold_handover inst%0d: got %b want grant 0010", k, obs(k));
      end
    end
  endtask

  task automatic test_timeout();
    logic want_t;
    apply_reset();
    drive(4'b0001, 1'b0);
    // grant appears after tick 1, is held for 4 cycles, timeout pulse after tick 5
    for (int i = 1; i <= 8; i++) begin
      tick();
      want_t = (i == 5);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k) || obs(k)[6] !== want_t || obs(k)[3:0] !== 4'b0001) begin
          errors++;
          $display("FAIL timeout inst%0d cyc%0d: got %b want tout=%0b grant 0001", k, i, obs(k), want_t);
        end
      end
    end
    // counter is at its limit again on the next edge; ack there suppresses the pulse
    drive(4'b0001, 1'b1);
    tick();
    drive(4'b0001, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== expv(k) || obs(k)[6] !== 1'b0) begin
        errors++;
        $display("FAIL ack_beats_timeout inst%0d: got %b want %b", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    drive(4'b0010, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 8'h00 || obs(k) !== expv(k)) begin
        errors++;
        $display("FAIL withdraw inst%0d: got %b want %b", k, obs(k), 8'h00);
      end
    end
  endtask

  task automatic test_ack_idle();
    apply_reset();
    drive(4'b0000, 1'b1);
    tick();
    tick();
    drive(4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 8'h00 || obs(k) !== expv(k)) begin
        errors++;
        $display("FAIL ack_in_idle inst%0d: got %b want %b", k, obs(k), 8'h00);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(4'b0011, 1'b0);
    tick();
    drive(4'b0011, 1'b1);
    tick();
    drive(4'b0011, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== 8'h00) begin
        errors++;
        $display("FAIL async_reset inst%0d: got %b want %b", k, obs(k), 8'h00);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k)[3:0] !== 4'b0001 || obs(k) !== expv(k)) begin
        errors++;
        $display("FAIL async_restart inst%0d: got %b want grant 0001", k, obs(k));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req_v[0] = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) req_v[1] = 4'($urandom_range(0, 15));
      ack_v[0] = ($urandom_range(0, 3) == 0);
      ack_v[1] = ($urandom_range(0, 3) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
        end
      end
    end
    drive(4'b0000, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 1'b0);
    model_reset();
    test_reset();
    test_round_robin();
    test_hold();
    test_timeout();
    test_withdraw();
    test_ack_idle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
